// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
// The slave modport is the arbiter; the master modport is the surrounding pipeline/ALU.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [DATA_WIDTH-1:0]    req0_srca;
  logic [DATA_WIDTH-1:0]    req0_srcb;
  logic [OPCODE_LENGTH-1:0] req0_op;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [DATA_WIDTH-1:0]    req1_srca;
  logic [DATA_WIDTH-1:0]    req1_srcb;
  logic [OPCODE_LENGTH-1:0] req1_op;

  logic                     rsp0_valid;
  logic [DATA_WIDTH-1:0]    rsp0_result;
  logic                     rsp0_ready;

  logic                     rsp1_valid;
  logic [DATA_WIDTH-1:0]    rsp1_result;
  logic                     rsp1_ready;

  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport slave (
    input  req0_valid, req0_srca, req0_srcb, req0_op,
    input  req1_valid, req1_srca, req1_srcb, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output alu_srca, alu_srcb, alu_op
  );

  modport master (
    output req0_valid, req0_srca, req0_srcb, req0_op,
    output req1_valid, req1_srca, req1_srcb, req1_op,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  alu_srca, alu_srcb, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// per-requester response register held until the requester consumes it.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  alu_arbiter_if.slave bus
);

  logic                  elig0, elig1;
  logic                  grant0, grant1;
  logic                  last_grant_q, last_grant_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;

  // A full response register only blocks its requester if it is not draining now.
  always_comb begin
    elig0  = bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
    elig1  = bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_ni) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_comb begin
    bus.alu_srca = '0;
    bus.alu_srcb = '0;
    bus.alu_op   = '0;
    if (grant0) begin
      bus.alu_srca = bus.req0_srca;
      bus.alu_srcb = bus.req0_srcb;
      bus.alu_op   = bus.req0_op;
    end else if (grant1) begin
      bus.alu_srca = bus.req1_srca;
      bus.alu_srcb = bus.req1_srcb;
      bus.alu_op   = bus.req1_op;
    end
  end

  // A new capture wins over a drain so back-to-back results have no bubble.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    last_grant_d  = last_grant_q;

    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = bus.alu_result;
      last_grant_d  = 1'b0;
    end else if (bus.rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = bus.alu_result;
      last_grant_d  = 1'b1;
    end else if (bus.rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU behind the arbiter.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpEq  = 4'b1000;
  localparam logic [3:0] OpBad = 4'b1111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: unsupported opcodes return zero.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      OpAnd:   bus.alu_result = bus.alu_srca & bus.alu_srcb;
      OpOr:    bus.alu_result = bus.alu_srca | bus.alu_srcb;
      OpAdd:   bus.alu_result = bus.alu_srca + bus.alu_srcb;
      OpEq:    bus.alu_result = (bus.alu_srca == bus.alu_srcb) ? 32'd1 : 32'd0;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
    bus.req0_valid = v;
    bus.req0_srca  = a;
    bus.req0_srcb  = b;
    bus.req0_op    = op;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
    bus.req1_valid = v;
    bus.req1_srca  = a;
    bus.req1_srcb  = b;
    bus.req1_op    = op;
  endtask

  initial begin
    set_req0(1'b0, 32'd0, 32'd0, OpAnd);
    set_req1(1'b0, 32'd0, 32'd0, OpAnd);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset: a valid request must not be accepted and the ALU sees zeros.
    rst_n = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, OpAdd);
    #1;
    chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_alu_srca", bus.alu_srca, 32'd0);
    chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    tick();
    chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("rst_rsp0_result", bus.rsp0_result, 32'd0);
    chk("rst_rsp1_result", bus.rsp1_result, 32'd0);

    // Single ADD on requester 0.
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    #1;
    chk("add_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("add_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    chk("add_alu_srca", bus.alu_srca, 32'd5);
    chk("add_alu_op", {28'd0, bus.alu_op}, {28'd0, OpAdd});
    tick();
    set_req0(1'b0, 32'd0, 32'd0, OpAnd);
    chk("add_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    chk("add_rsp0_result", bus.rsp0_result, 32'd12);
    chk("add_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    tick();
    chk("drain_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("drain_rsp0_hold", bus.rsp0_result, 32'd12);

    // Continuous contention from reset: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req0(1'b1, 32'h0F0F, 32'h00FF, OpAnd);
    set_req1(1'b1, 32'hF000, 32'h000F, OpOr);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_req0_ready", {31'd0, bus.req0_ready}, {31'd0, (i % 2) == 0});
      chk("rr_req1_ready", {31'd0, bus.req1_ready}, {31'd0, (i % 2) == 1});
      tick();
    end
    chk("rr_rsp0_result", bus.rsp0_result, 32'h0000_000F);
    chk("rr_rsp1_result", bus.rsp1_result, 32'h0000_F00F);
    chk("rr_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
    set_req0(1'b0, 32'd0, 32'd0, OpAnd);
    set_req1(1'b0, 32'd0, 32'd0, OpAnd);
    tick();
    tick();

    // Held response blocks requester 1 until it is drained; back-to-back on drain.
    bus.rsp1_ready = 1'b0;
    set_req1(1'b1, 32'h1234, 32'h1234, OpEq);
    #1;
    chk("eq_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    set_req1(1'b1, 32'd1, 32'd2, OpEq);
    #1;
    chk("eq_rsp1_result", bus.rsp1_result, 32'd1);
    chk("eq_blocked", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    chk("eq_held_result", bus.rsp1_result, 32'd1);
    chk("eq_held_valid", {31'd0, bus.rsp1_valid}, 32'd1);
    chk("eq_still_blocked", {31'd0, bus.req1_ready}, 32'd0);
    bus.rsp1_ready = 1'b1;
    #1;
    chk("eq_b2b_ready", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    chk("eq_b2b_valid", {31'd0, bus.rsp1_valid}, 32'd1);
    chk("eq_b2b_result", bus.rsp1_result, 32'd0);
    set_req1(1'b0, 32'd0, 32'd0, OpAnd);
    tick();

    // Full rsp0 with no drain: only requester 1 is granted, every cycle.
    bus.rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd1, 32'd1, OpAdd);
    #1;
    chk("fill_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req1(1'b1, 32'd10, 32'd20, OpAdd);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("blk_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      chk("blk_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
      tick();
    end
    chk("blk_rsp0_result", bus.rsp0_result, 32'd2);
    chk("blk_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    chk("blk_rsp1_result", bus.rsp1_result, 32'd30);

    // Unsupported opcode is captured as an ordinary (zero) result.
    set_req1(1'b0, 32'd0, 32'd0, OpAnd);
    bus.rsp0_ready = 1'b1;
    set_req0(1'b1, 32'd3, 32'd4, OpBad);
    #1;
    chk("bad_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("bad_alu_op", {28'd0, bus.alu_op}, 32'hF);
    tick();
    chk("bad_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    chk("bad_rsp0_result", bus.rsp0_result, 32'd0);

    // Reset right after a capture discards the result and rearms the tie-break.
    set_req0(1'b1, 32'd5, 32'd7, OpAdd);
    tick();
    chk("mid_rsp0_result", bus.rsp0_result, 32'd12);
    rst_n = 1'b0;
    bus.rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd1, 32'd1, OpAdd);
    #1;
    chk("mid_rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    chk("mid_rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("mid_rst_rsp0_result", bus.rsp0_result, 32'd0);
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set_req0(1'b1, 32'h0F0F, 32'h00FF, OpAnd);
    set_req1(1'b1, 32'hF000, 32'h000F, OpOr);
    #1;
    chk("post_tie_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("post_tie_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    chk("post_tie_alu_srca", bus.alu_srca, 32'h0F0F);
    tick();
    chk("post_tie_rsp0_result", bus.rsp0_result, 32'h0000_000F);
    chk("post_tie_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
